decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_pkg.sv | 100 ++++++++++
 rtl/mips_ctrl_decode.sv | 100 ++++++++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the control / ID-EX bundles
// used by the decode stage and its control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2
  } imm_e;

  typedef struct packed {
    alu_op_e aluOp;
    logic    aluSrc;
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    branch_e branch;
    imm_e    immKind;
    logic    destRt;
    logic    usesRt;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  destReg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  branch;
    logic        illegal;
  } id_ex_t;

  function automatic logic [31:0] extendImm(
    input imm_e        kind,
    input logic [15:0] raw
  );
    unique case (kind)
      IMM_ZERO:  extendImm = {16'h0, raw};
      IMM_UPPER: extendImm = {raw, 16'h0};
      default:   extendImm = {{16{raw[15]}}, raw};
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct to control-field decoder.
// Unknown encodings raise illegal with all side effects off.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] Opcode_IN,
  input  logic [5:0] Funct_IN,
  output ctrl_t      Ctrl_OUT
);

  ctrl_t c;

  always_comb begin
    c = '0;
    c.aluOp   = ALU_ADD;
    c.branch  = BR_NONE;
    c.immKind = IMM_SIGN;
    unique case (1'b1)
      (Opcode_IN == OP_RTYPE): begin
        c.regWrite = 1'b1;
        c.usesRt   = 1'b1;
        case (Funct_IN)
          FN_ADD, FN_ADDU: c.aluOp = ALU_ADD;
          FN_SUB, FN_SUBU: c.aluOp = ALU_SUB;
          FN_AND:  c.aluOp = ALU_AND;
          FN_OR:   c.aluOp = ALU_OR;
          FN_XOR:  c.aluOp = ALU_XOR;
          FN_NOR:  c.aluOp = ALU_NOR;
          FN_SLT:  c.aluOp = ALU_SLT;
          FN_SLTU: c.aluOp = ALU_SLTU;
          FN_SLL:  c.aluOp = ALU_SLL;
          FN_SRL:  c.aluOp = ALU_SRL;
          FN_SRA:  c.aluOp = ALU_SRA;
          default: begin
            c.regWrite = 1'b0;
            c.illegal  = 1'b1;
          end
        endcase
      end
      (Opcode_IN == OP_ADDI),
      (Opcode_IN == OP_ADDIU): begin
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.destRt   = 1'b1;
      end
      (Opcode_IN == OP_SLTI): begin
        c.aluOp    = ALU_SLT;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.destRt   = 1'b1;
      end
      (Opcode_IN == OP_ANDI): begin
        c.aluOp    = ALU_AND;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.destRt   = 1'b1;
        c.immKind  = IMM_ZERO;
      end
      (Opcode_IN == OP_ORI): begin
        c.aluOp    = ALU_OR;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.destRt   = 1'b1;
        c.immKind  = IMM_ZERO;
      end
      (Opcode_IN == OP_LUI): begin
        c.aluOp    = ALU_LUI;
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.destRt   = 1'b1;
        c.immKind  = IMM_UPPER;
      end
      (Opcode_IN == OP_LW): begin
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.memRead  = 1'b1;
        c.destRt   = 1'b1;
      end
      (Opcode_IN == OP_SW): begin
        c.aluSrc   = 1'b1;
        c.memWrite = 1'b1;
        c.usesRt   = 1'b1;
      end
      (Opcode_IN == OP_BEQ): begin
        c.aluOp  = ALU_SUB;
        c.branch = BR_EQ;
        c.usesRt = 1'b1;
      end
      (Opcode_IN == OP_BNE): begin
        c.aluOp  = ALU_SUB;
        c.branch = BR_NE;
        c.usesRt = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
  end

  assign Ctrl_OUT = c;

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: operand bypass, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage
  import mips_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] Instr_IN,
  input  logic        InstrValid_IN,
  input  logic [31:0] PC_IN,
  output logic [4:0]  ReadRegister1_OUT,
  output logic [4:0]  ReadRegister2_OUT,
  input  logic [31:0] ReadData1_IN,
  input  logic [31:0] ReadData2_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic [31:0] WriteData_IN,
  input  logic        WriteEnable_IN,
  input  logic        ExStall_IN,
  input  logic        Flush_IN,
  output logic        Stall_OUT,
  output logic        Valid_OUT,
  output logic [31:0] PC_OUT,
  output logic [31:0] RsData_OUT,
  output logic [31:0] RtData_OUT,
  output logic [31:0] Imm_OUT,
  output logic [4:0]  DestReg_OUT,
  output logic [4:0]  Rs_OUT,
  output logic [4:0]  Rt_OUT,
  output logic [3:0]  AluOp_OUT,
  output logic        AluSrc_OUT,
  output logic        RegWrite_OUT,
  output logic        MemRead_OUT,
  output logic        MemWrite_OUT,
  output logic [1:0]  Branch_OUT,
  output logic        Illegal_OUT
);

  logic [4:0] rs, rt, rd, dest;
  ctrl_t      ctrl;
  id_ex_t     idEx, decoded;
  logic       hazard, rsHit, rtHit;

  assign rs = Instr_IN[25:21];
  assign rt = Instr_IN[20:16];
  assign rd = Instr_IN[15:11];

  assign ReadRegister1_OUT = rs;
  assign ReadRegister2_OUT = rt;

  mips_ctrl_decode u_ctrl (
    .Opcode_IN (Instr_IN[31:26]),
    .Funct_IN  (Instr_IN[5:0]),
    .Ctrl_OUT  (ctrl)
  );

  function automatic logic [31:0] operand(
    input logic [4:0]  idx,
    input logic [31:0] rf,
    input logic        we,
    input logic [4:0]  wr,
    input logic [31:0] wd
  );
    if (idx == 5'd0)
      operand = 32'h0;
    else if (we && wr == idx)
      operand = wd;
    else
      operand = rf;
  endfunction

  assign dest = !ctrl.regWrite ? 5'd0
              : ctrl.destRt ? rt : rd;

  assign rsHit  = (idEx.destReg == rs);
  assign rtHit  = ctrl.usesRt && (idEx.destReg == rt);
  assign hazard = idEx.valid && idEx.memRead
               && (idEx.destReg != 5'd0)
               && InstrValid_IN && (rsHit || rtHit);

  assign Stall_OUT = hazard || ExStall_IN;

  always_comb begin
    decoded = '0;
    if (ctrl.illegal) begin
      decoded.illegal = 1'b1;
    end else begin
      decoded.valid    = 1'b1;
      decoded.pc       = PC_IN;
      decoded.rsData   = operand(rs, ReadData1_IN,
        WriteEnable_IN, WriteRegister_IN, WriteData_IN);
      decoded.rtData   = operand(rt, ReadData2_IN,
        WriteEnable_IN, WriteRegister_IN, WriteData_IN);
      decoded.imm      = extendImm(ctrl.immKind,
        Instr_IN[15:0]);
      decoded.destReg  = dest;
      decoded.rs       = rs;
      decoded.rt       = rt;
      decoded.aluOp    = ctrl.aluOp;
      decoded.aluSrc   = ctrl.aluSrc;
      decoded.regWrite = ctrl.regWrite && (dest != 5'd0);
      decoded.memRead  = ctrl.memRead;
      decoded.memWrite = ctrl.memWrite;
      decoded.branch   = ctrl.branch;
    end
  end

  // flush beats stall; a held ID/EX ignores hazards
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      idEx <= '0;
    else if (Flush_IN)
      idEx <= '0;
    else if (ExStall_IN)
      idEx <= idEx;
    else if (hazard || !InstrValid_IN)
      idEx <= '0;
    else
      idEx <= decoded;
  end

  assign Valid_OUT    = idEx.valid;
  assign PC_OUT       = idEx.pc;
  assign RsData_OUT   = idEx.rsData;
  assign RtData_OUT   = idEx.rtData;
  assign Imm_OUT      = idEx.imm;
  assign DestReg_OUT  = idEx.destReg;
  assign Rs_OUT       = idEx.rs;
  assign Rt_OUT       = idEx.rt;
  assign AluOp_OUT    = idEx.aluOp;
  assign AluSrc_OUT   = idEx.aluSrc;
  assign RegWrite_OUT = idEx.regWrite;
  assign MemRead_OUT  = idEx.memRead;
  assign MemWrite_OUT = idEx.memWrite;
  assign Branch_OUT   = idEx.branch;
  assign Illegal_OUT  = idEx.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with
// hand-computed expectations.
module tb_decode_stage;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_IN;
  logic        InstrValid_IN;
  logic [31:0] PC_IN;
  logic [4:0]  ReadRegister1_OUT;
  logic [4:0]  ReadRegister2_OUT;
  logic [31:0] ReadData1_IN;
  logic [31:0] ReadData2_IN;
  logic [4:0]  WriteRegister_IN;
  logic [31:0] WriteData_IN;
  logic        WriteEnable_IN;
  logic        ExStall_IN;
  logic        Flush_IN;
  logic        Stall_OUT;
  logic        Valid_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] RsData_OUT;
  logic [31:0] RtData_OUT;
  logic [31:0] Imm_OUT;
  logic [4:0]  DestReg_OUT;
  logic [4:0]  Rs_OUT;
  logic [4:0]  Rt_OUT;
  logic [3:0]  AluOp_OUT;
  logic        AluSrc_OUT;
  logic        RegWrite_OUT;
  logic        MemRead_OUT;
  logic        MemWrite_OUT;
  logic [1:0]  Branch_OUT;
  logic        Illegal_OUT;

  int nVec = 0;
  int nErr = 0;

  always #5 CLOCK = ~CLOCK;

  decode_stage dut (
    .CLOCK             (CLOCK),
    .RESET             (RESET),
    .Instr_IN          (Instr_IN),
    .InstrValid_IN     (InstrValid_IN),
    .PC_IN             (PC_IN),
    .ReadRegister1_OUT (ReadRegister1_OUT),
    .ReadRegister2_OUT (ReadRegister2_OUT),
    .ReadData1_IN      (ReadData1_IN),
    .ReadData2_IN      (ReadData2_IN),
    .WriteRegister_IN  (WriteRegister_IN),
    .WriteData_IN      (WriteData_IN),
    .WriteEnable_IN    (WriteEnable_IN),
    .ExStall_IN        (ExStall_IN),
    .Flush_IN          (Flush_IN),
    .Stall_OUT         (Stall_OUT),
    .Valid_OUT         (Valid_OUT),
    .PC_OUT            (PC_OUT),
    .RsData_OUT        (RsData_OUT),
    .RtData_OUT        (RtData_OUT),
    .Imm_OUT           (Imm_OUT),
    .DestReg_OUT       (DestReg_OUT),
    .Rs_OUT            (Rs_OUT),
    .Rt_OUT            (Rt_OUT),
    .AluOp_OUT         (AluOp_OUT),
    .AluSrc_OUT        (AluSrc_OUT),
    .RegWrite_OUT      (RegWrite_OUT),
    .MemRead_OUT       (MemRead_OUT),
    .MemWrite_OUT      (MemWrite_OUT),
    .Branch_OUT        (Branch_OUT),
    .Illegal_OUT       (Illegal_OUT)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h",
        tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] instr,
    input logic [31:0] pc,
    input logic [31:0] rd1,
    input logic [31:0] rd2
  );
    Instr_IN      = instr;
    PC_IN         = pc;
    ReadData1_IN  = rd1;
    ReadData2_IN  = rd2;
    InstrValid_IN = 1'b1;
  endtask

  logic [31:0] holdRs;
  logic [4:0]  holdDest;

  initial begin
    RESET = 1'b0;
    Instr_IN = '0; InstrValid_IN = 1'b0;
    PC_IN = '0; ReadData1_IN = '0;
    ReadData2_IN = '0; WriteRegister_IN = '0;
    WriteData_IN = '0; WriteEnable_IN = 1'b0;
    ExStall_IN = 1'b0; Flush_IN = 1'b0;
    #12;
    chk("rst valid", Valid_OUT, 0);
    chk("rst pc", PC_OUT, 0);
    chk("rst imm", Imm_OUT, 0);
    chk("rst regwr", RegWrite_OUT, 0);
    chk("rst illegal", Illegal_OUT, 0);
    RESET = 1'b1;
    step();

    // ADDI r8,r0,5 with r0 write snoop that must be ignored
    drive(32'h20080005, 32'h104, 32'h1234, 32'h0);
    WriteEnable_IN = 1'b1;
    WriteRegister_IN = 5'd0;
    WriteData_IN = 32'hFFFFFFFF;
    chk("addi rr1", ReadRegister1_OUT, 0);
    chk("addi rr2", ReadRegister2_OUT, 8);
    chk("addi stall", Stall_OUT, 0);
    step();
    WriteEnable_IN = 1'b0;
    chk("addi valid", Valid_OUT, 1);
    chk("addi imm", Imm_OUT, 5);
    chk("addi dest", DestReg_OUT, 8);
    chk("addi regwr", RegWrite_OUT, 1);
    chk("addi rsdata", RsData_OUT, 0);
    chk("addi pc", PC_OUT, 32'h104);
    chk("addi alusrc", AluSrc_OUT, 1);

    // LW r9,0(r8)
    drive(32'h8D090000, 32'h108, 32'h100, 32'h0);
    step();
    chk("lw memrd", MemRead_OUT, 1);
    chk("lw dest", DestReg_OUT, 9);
    chk("lw rsdata", RsData_OUT, 32'h100);

    // ADD r10,r9,r9 -> one load-use bubble
    drive(32'h01295020, 32'h10C, 32'h7, 32'h7);
    #1;
    chk("luse stall", Stall_OUT, 1);
    step();
    chk("luse bub valid", Valid_OUT, 0);
    chk("luse bub regwr", RegWrite_OUT, 0);
    chk("luse bub memrd", MemRead_OUT, 0);
    chk("luse unstall", Stall_OUT, 0);
    step();
    chk("add valid", Valid_OUT, 1);
    chk("add dest", DestReg_OUT, 10);
    chk("add aluop", AluOp_OUT, 0);
    chk("add pc", PC_OUT, 32'h10C);

    // ORI r11,r9,0x8001 with same-cycle write of r9
    drive(32'h352B8001, 32'h110, 32'h11111111, 32'h0);
    WriteEnable_IN = 1'b1;
    WriteRegister_IN = 5'd9;
    WriteData_IN = 32'hDEADBEEF;
    step();
    WriteEnable_IN = 1'b0;
    chk("byp rsdata", RsData_OUT, 32'hDEADBEEF);
    chk("ori imm", Imm_OUT, 32'h00008001);
    chk("ori aluop", AluOp_OUT, 3);
    chk("ori dest", DestReg_OUT, 11);

    // SUB r12,r1,r2 held by ExStall for three cycles
    drive(32'h00226022, 32'h114, 32'h5, 32'h3);
    ExStall_IN = 1'b1;
    holdRs = RsData_OUT;
    holdDest = DestReg_OUT;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("exst stall", Stall_OUT, 1);
      step();
      chk("exst rs", RsData_OUT, holdRs);
      chk("exst dest", DestReg_OUT, holdDest);
      chk("exst pc", PC_OUT, 32'h110);
    end
    ExStall_IN = 1'b0;
    step();
    chk("sub dest", DestReg_OUT, 12);
    chk("sub aluop", AluOp_OUT, 1);
    chk("sub rs", RsData_OUT, 5);
    chk("sub rt", RtData_OUT, 3);

    // LUI r13,0xABCD
    drive(32'h3C0DABCD, 32'h118, 32'h0, 32'h0);
    step();
    chk("lui imm", Imm_OUT, 32'hABCD0000);
    chk("lui aluop", AluOp_OUT, 11);

    // SLTI r14,r0,-2
    drive(32'h280EFFFE, 32'h11C, 32'h0, 32'h0);
    step();
    chk("slti imm", Imm_OUT, 32'hFFFFFFFE);
    chk("slti aluop", AluOp_OUT, 6);

    // SW r5,4(r6)
    drive(32'hACC50004, 32'h120, 32'h40, 32'h99);
    step();
    chk("sw memwr", MemWrite_OUT, 1);
    chk("sw regwr", RegWrite_OUT, 0);
    chk("sw rt", RtData_OUT, 32'h99);

    // ADDI r0,r0,1: write to r0 suppressed
    drive(32'h20000001, 32'h124, 32'h0, 32'h0);
    step();
    chk("r0 valid", Valid_OUT, 1);
    chk("r0 regwr", RegWrite_OUT, 0);

    // BEQ under flush and ExStall together
    drive(32'h10220003, 32'h128, 32'h1, 32'h1);
    Flush_IN = 1'b1;
    ExStall_IN = 1'b1;
    step();
    chk("flush valid", Valid_OUT, 0);
    chk("flush branch", Branch_OUT, 0);
    Flush_IN = 1'b0;
    ExStall_IN = 1'b0;
    step();
    chk("beq valid", Valid_OUT, 1);
    chk("beq branch", Branch_OUT, 1);

    // illegal opcode, then illegal funct, then legal
    drive(32'hFC000000, 32'h12C, 32'h0, 32'h0);
    step();
    chk("ill op flag", Illegal_OUT, 1);
    chk("ill op valid", Valid_OUT, 0);
    chk("ill op regwr", RegWrite_OUT, 0);
    drive(32'h0000003F, 32'h130, 32'h0, 32'h0);
    step();
    chk("ill fn flag", Illegal_OUT, 1);
    drive(32'h01295020, 32'h134, 32'h0, 32'h0);
    step();
    chk("ill clear", Illegal_OUT, 0);
    chk("ill clr valid", Valid_OUT, 1);

    // LW r7 then ADDI r7: rt is a destination, not a source
    drive(32'h8C070000, 32'h138, 32'h0, 32'h0);
    step();
    drive(32'h20070001, 32'h13C, 32'h0, 32'h0);
    #1;
    chk("noluse stall", Stall_OUT, 0);
    step();
    chk("noluse valid", Valid_OUT, 1);

    // BNE r7,r7 after LW r7: rt source -> stall
    drive(32'h8C070000, 32'h140, 32'h0, 32'h0);
    step();
    drive(32'h14E7FFFF, 32'h144, 32'h0, 32'h0);
    #1;
    chk("bne stall", Stall_OUT, 1);
    step();
    step();
    chk("bne branch", Branch_OUT, 2);
    chk("bne imm", Imm_OUT, 32'hFFFFFFFF);

    InstrValid_IN = 1'b0;
    step();
    chk("nv valid", Valid_OUT, 0);

    // reset mid-stall
    drive(32'h20080005, 32'h148, 32'h0, 32'h0);
    step();
    ExStall_IN = 1'b1;
    drive(32'h200F0007, 32'h14C, 32'h0, 32'h0);
    step();
    #2;
    RESET = 1'b0;
    #1;
    chk("arst valid", Valid_OUT, 0);
    chk("arst pc", PC_OUT, 0);
    chk("arst imm", Imm_OUT, 0);
    chk("arst dest", DestReg_OUT, 0);
    RESET = 1'b1;
    ExStall_IN = 1'b0;
    step();
    chk("post rst valid", Valid_OUT, 1);
    chk("post rst dest", DestReg_OUT, 15);
    chk("post rst pc", PC_OUT, 32'h14C);

    $display("== %0d vectors applied, %0d miscompares ==",
      nVec, nErr);
    $finish;
  end

endmodule
